// File: rtl/mux_array_ctrl.sv
// Issue sequencer for mux_array: walks the select through every input group of
// each sliding window, handshakes with the line buffer and the PE array, and tags beats.
module mux_array_ctrl #(
    parameter int Nin         = 3,
    parameter int Pin         = 2,
    parameter int NUM_WINDOWS = 16,
    localparam int NUM_INPUT  = (Nin + Pin - 1) / Pin,
    localparam int SEL_WIDTH  = (NUM_INPUT > 1) ? $clog2(NUM_INPUT) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 window_valid,
    output logic                 window_ready,
    output logic                 mux_enable,
    output logic [SEL_WIDTH-1:0] mux_select,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_first,
    output logic                 out_last,
    output logic                 out_frame_last,
    output logic                 frame_done
);

    localparam int WIN_W = (NUM_WINDOWS > 1) ? $clog2(NUM_WINDOWS) : 1;
    localparam logic [SEL_WIDTH-1:0] GRP_LAST = SEL_WIDTH'(NUM_INPUT - 1);
    localparam logic [WIN_W-1:0]     WIN_LAST = WIN_W'(NUM_WINDOWS - 1);

    logic [SEL_WIDTH-1:0] grp_cnt;
    logic [WIN_W-1:0]     win_cnt;
    logic                 issue;
    logic                 grp_is_last;
    logic                 win_is_last;

    // A new group may be captured whenever the output slot is empty or being drained.
    assign issue        = window_valid & (~out_valid | out_ready);
    assign grp_is_last  = (grp_cnt == GRP_LAST);
    assign win_is_last  = (win_cnt == WIN_LAST);
    assign mux_enable   = issue;
    assign mux_select   = grp_cnt;
    assign window_ready = issue & grp_is_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grp_cnt        <= '0;
            win_cnt        <= '0;
            out_valid      <= 1'b0;
            out_first      <= 1'b0;
            out_last       <= 1'b0;
            out_frame_last <= 1'b0;
            frame_done     <= 1'b0;
        end else begin
            frame_done <= out_valid & out_ready & out_frame_last;
            if (issue) begin
                out_valid      <= 1'b1;
                out_first      <= (grp_cnt == '0);
                out_last       <= grp_is_last;
                out_frame_last <= grp_is_last & win_is_last;
                if (grp_is_last) begin
                    grp_cnt <= '0;
                    win_cnt <= win_is_last ? '0 : win_cnt + 1'b1;
                end else begin
                    grp_cnt <= grp_cnt + 1'b1;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
